// File: rtl/rp_ctrl_pkg.sv
// Shared types for the reconfigurable-partition shutdown controller.
package rp_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  // Encodings are visible on the state output and must stay fixed.
  typedef enum logic [STATE_W-1:0] {
    StDecoupled = 3'd0,
    StRelease   = 3'd1,
    StActive    = 3'd2,
    StDrain     = 3'd3,
    StReq       = 3'd4
  } rp_state_e;

endpackage

// File: rtl/rp_txn_counter.sv
// Outstanding-transaction counter: saturating up/down, never below zero.
module rp_txn_counter #(
  parameter int unsigned OUTSTANDING_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic full
);

  localparam logic [OUTSTANDING_W-1:0] CntOne = {{(OUTSTANDING_W-1){1'b0}}, 1'b1};

  logic [OUTSTANDING_W-1:0] r_cnt;
  logic [OUTSTANDING_W-1:0] w_cnt_d;

  assign zero = (r_cnt == '0);
  assign full = (r_cnt == '1);

  // Next count: a simultaneous request and response cancel out; a response with nothing
  // outstanding is spurious and dropped.
  always_comb begin
    w_cnt_d = r_cnt;
    if (clr) begin
      w_cnt_d = '0;
    end else if (inc && !dec && !full) begin
      w_cnt_d = r_cnt + CntOne;
    end else if (dec && !inc && !zero) begin
      w_cnt_d = r_cnt - CntOne;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/rp_shutdown_ctrl.sv
// Static-side shutdown/decouple sequencer for a reconfigurable partition.
// Optional feature macro: RP_SHUTDOWN_TIMEOUT_EN (forces REQ -> DECOUPLED when the
// partition never acknowledges shutdown, and flags it on timeout_err).
module rp_shutdown_ctrl
  import rp_ctrl_pkg::*;
#(
  parameter int unsigned OUTSTANDING_W   = 4,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               decouple_req,
  output logic               rp_shutdown_req,
  input  logic               rp_shutdown_ack,
  input  logic               rp_active,
  output logic               rp_rst_n,
  output logic               decouple,
  output logic               hold_addr,
  input  logic               mon_awvalid,
  input  logic               mon_awready,
  input  logic               mon_bvalid,
  input  logic               mon_bready,
  input  logic               mon_arvalid,
  input  logic               mon_arready,
  input  logic               mon_rvalid,
  input  logic               mon_rready,
  input  logic               mon_rlast,
  output logic [STATE_W-1:0] state,
  output logic               timeout_err
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(RST_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

  rp_state_e         r_state;
  rp_state_e         w_state_d;
  logic [HOLD_W-1:0] r_hold;
  logic              w_hold_done;
  logic              w_wr_zero;
  logic              w_wr_full;
  logic              w_rd_zero;
  logic              w_rd_full;
  logic              w_cnt_clr;
  logic              w_aw_hs;
  logic              w_b_hs;
  logic              w_ar_hs;
  logic              w_r_last_hs;
  logic              w_timeout_fire;

  assign w_aw_hs     = mon_awvalid & mon_awready;
  assign w_b_hs      = mon_bvalid & mon_bready;
  assign w_ar_hs     = mon_arvalid & mon_arready;
  assign w_r_last_hs = mon_rvalid & mon_rready & mon_rlast;
  assign w_cnt_clr   = (r_state == StDecoupled);
  assign w_hold_done = (r_hold >= HoldMax);

  rp_txn_counter #(
    .OUTSTANDING_W (OUTSTANDING_W)
  ) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_aw_hs),
    .dec  (w_b_hs),
    .clr  (w_cnt_clr),
    .zero (w_wr_zero),
    .full (w_wr_full)
  );

  rp_txn_counter #(
    .OUTSTANDING_W (OUTSTANDING_W)
  ) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_ar_hs),
    .dec  (w_r_last_hs),
    .clr  (w_cnt_clr),
    .zero (w_rd_zero),
    .full (w_rd_full)
  );

  // Reset-hold counter: zero outside DECOUPLED so every entry starts a fresh hold period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state != StDecoupled) begin
      r_hold <= '0;
    end else if (!w_hold_done) begin
      r_hold <= r_hold + HoldOne;
    end
  end

`ifdef RP_SHUTDOWN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] ToOne  = TO_W'(1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  assign w_timeout_fire = (r_state == StReq) && !rp_shutdown_ack && (r_to_cnt == ToLast);
  assign timeout_err    = r_timeout_err;

  // Cycles spent waiting for the shutdown ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != StReq) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != ToLast) begin
      r_to_cnt <= r_to_cnt + ToOne;
    end
  end

  // Sticky timeout flag, cleared when a new drain begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (r_state == StActive && w_state_d == StDrain) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout_fire) begin
      r_timeout_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout_fire   = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StDecoupled;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    w_state_d       = r_state;
    decouple        = 1'b1;
    hold_addr       = 1'b1;
    rp_rst_n        = 1'b0;
    rp_shutdown_req = 1'b0;
    unique case (r_state)
      StDecoupled: begin
        if (!decouple_req && w_hold_done) begin
          w_state_d = StRelease;
        end
      end
      StRelease: begin
        rp_rst_n = 1'b1;
        if (decouple_req) begin
          w_state_d = StDecoupled;
        end else if (rp_active) begin
          w_state_d = StActive;
        end
      end
      StActive: begin
        decouple  = 1'b0;
        // Stop new addresses while a counter cannot record another transaction.
        hold_addr = w_wr_full | w_rd_full;
        rp_rst_n  = 1'b1;
        if (decouple_req) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        decouple = 1'b0;
        rp_rst_n = 1'b1;
        if (!decouple_req) begin
          w_state_d = StActive;
        end else if (w_wr_zero && w_rd_zero) begin
          w_state_d = StReq;
        end
      end
      StReq: begin
        decouple        = 1'b0;
        rp_rst_n        = 1'b1;
        rp_shutdown_req = 1'b1;
        // Committed: decouple_req is ignored here.
        if (rp_shutdown_ack || w_timeout_fire) begin
          w_state_d = StDecoupled;
        end
      end
      default: begin
        w_state_d = StDecoupled;
      end
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_rp_shutdown_ctrl.sv
// Directed bench for rp_shutdown_ctrl. Define RP_SHUTDOWN_TIMEOUT_EN to cover the timeout path.
module tb_rp_shutdown_ctrl;

  logic       clk;
  logic       rst;
  logic       decouple_req;
  logic       rp_shutdown_req;
  logic       rp_shutdown_ack;
  logic       rp_active;
  logic       rp_rst_n;
  logic       decouple;
  logic       hold_addr;
  logic       mon_awvalid;
  logic       mon_awready;
  logic       mon_bvalid;
  logic       mon_bready;
  logic       mon_arvalid;
  logic       mon_arready;
  logic       mon_rvalid;
  logic       mon_rready;
  logic       mon_rlast;
  logic [2:0] state;
  logic       timeout_err;

  int n_cmp;
  int n_err;

  rp_shutdown_ctrl #(
    .OUTSTANDING_W   (4),
    .RST_HOLD_CYCLES (16),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .decouple_req    (decouple_req),
    .rp_shutdown_req (rp_shutdown_req),
    .rp_shutdown_ack (rp_shutdown_ack),
    .rp_active       (rp_active),
    .rp_rst_n        (rp_rst_n),
    .decouple        (decouple),
    .hold_addr       (hold_addr),
    .mon_awvalid     (mon_awvalid),
    .mon_awready     (mon_awready),
    .mon_bvalid      (mon_bvalid),
    .mon_bready      (mon_bready),
    .mon_arvalid     (mon_arvalid),
    .mon_arready     (mon_arready),
    .mon_rvalid      (mon_rvalid),
    .mon_rready      (mon_rready),
    .mon_rlast       (mon_rlast),
    .state           (state),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output vector: state, decouple, hold_addr, rp_rst_n, rp_shutdown_req.
  task automatic chk_out(input string tag, input logic [2:0] st, input logic dc,
                         input logic ha, input logic rn, input logic sr);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
    chk({tag, ".decouple"}, {31'd0, decouple}, {31'd0, dc});
    chk({tag, ".hold_addr"}, {31'd0, hold_addr}, {31'd0, ha});
    chk({tag, ".rp_rst_n"}, {31'd0, rp_rst_n}, {31'd0, rn});
    chk({tag, ".shutdown_req"}, {31'd0, rp_shutdown_req}, {31'd0, sr});
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st);
    chk(tag, {29'd0, state}, {29'd0, st});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    decouple_req = 1'b1;
    rp_active = 1'b0;
    rp_shutdown_ack = 1'b0;
    {mon_awvalid, mon_awready, mon_bvalid, mon_bready} = '0;
    {mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rlast} = '0;

    // Reset values
    tick(2);
    chk_out("reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset.timeout_err", {31'd0, timeout_err}, 32'd0);

    // Reset release: RELEASE after edge 17, ACTIVE after edge 19 (rp_active from cycle 18)
    rst = 1'b0;
    decouple_req = 1'b0;
    tick(16);
    chk_out("hold_16", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("release", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_st("release_wait_active", 3'd1);
    rp_active = 1'b1;
    tick(1);
    chk_out("active", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);

    // Drain with three outstanding writes
    {mon_awvalid, mon_awready} = 2'b11;
    tick(3);
    {mon_awvalid, mon_awready} = 2'b00;
    chk_st("active_3aw", 3'd2);
    decouple_req = 1'b1;
    tick(1);
    chk_out("drain", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    {mon_bvalid, mon_bready} = 2'b11;
    tick(2);
    chk_st("drain_2b", 3'd3);
    tick(1);
    chk_st("drain_3b_edge", 3'd3);
    {mon_bvalid, mon_bready} = 2'b00;
    tick(1);
    chk_out("req", 3'd4, 1'b0, 1'b1, 1'b1, 1'b1);

    // REQ is committed even if decouple_req falls
    decouple_req = 1'b0;
    tick(3);
    chk_st("req_committed", 3'd4);

    // Shutdown ack
    rp_shutdown_ack = 1'b1;
    tick(1);
    rp_shutdown_ack = 1'b0;
    chk_out("ack_decoupled", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // RELEASE aborted by decouple_req
    rp_active = 1'b0;
    tick(17);
    chk_st("release2", 3'd1);
    decouple_req = 1'b1;
    tick(1);
    chk_out("release_abort", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    decouple_req = 1'b0;
    rp_active = 1'b1;
    tick(17);
    chk_st("release3", 3'd1);
    tick(1);
    chk_st("active3", 3'd2);

    // Ack outside REQ ignored
    rp_shutdown_ack = 1'b1;
    tick(1);
    rp_shutdown_ack = 1'b0;
    chk_st("ack_ignored", 3'd2);

    // Read count 1, then simultaneous AR and R+rlast, then R without rlast
    {mon_arvalid, mon_arready} = 2'b11;
    tick(1);
    {mon_rvalid, mon_rready, mon_rlast} = 3'b111;
    tick(1);
    {mon_arvalid, mon_arready, mon_rlast} = 3'b000;
    tick(1);
    {mon_rvalid, mon_rready} = 2'b00;
    decouple_req = 1'b1;
    tick(1);
    chk_st("sim_drain", 3'd3);
    tick(1);
    chk_st("sim_count_nonzero", 3'd3);
    decouple_req = 1'b0;
    tick(1);
    chk_out("drain_abort", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    {mon_rvalid, mon_rready, mon_rlast} = 3'b111;
    tick(1);
    {mon_rvalid, mon_rready, mon_rlast} = 3'b000;
    decouple_req = 1'b1;
    tick(1);
    chk_st("sim_drain2", 3'd3);
    tick(1);
    chk_st("drain_one_cycle", 3'd4);
    rp_shutdown_ack = 1'b1;
    tick(1);
    rp_shutdown_ack = 1'b0;
    chk_st("ack2", 3'd0);

    // Back to ACTIVE
    decouple_req = 1'b0;
    tick(17);
    chk_st("release4", 3'd1);
    tick(1);
    chk_st("active4", 3'd2);

    // Spurious B with write count 0 must not wrap to full
    {mon_bvalid, mon_bready} = 2'b11;
    tick(1);
    {mon_bvalid, mon_bready} = 2'b00;
    chk("b_underflow.hold_addr", {31'd0, hold_addr}, 32'd0);

    // Read saturation at 15
    {mon_arvalid, mon_arready} = 2'b11;
    tick(14);
    chk("ar14.hold_addr", {31'd0, hold_addr}, 32'd0);
    tick(1);
    chk("ar15.hold_addr", {31'd0, hold_addr}, 32'd1);
    chk_st("ar15.state", 3'd2);
    tick(1);
    chk("ar16.hold_addr", {31'd0, hold_addr}, 32'd1);
    {mon_arvalid, mon_arready} = 2'b00;
    {mon_rvalid, mon_rready, mon_rlast} = 3'b111;
    tick(1);
    chk("r1.hold_addr", {31'd0, hold_addr}, 32'd0);
    tick(13);
    {mon_rvalid, mon_rready, mon_rlast} = 3'b000;
    decouple_req = 1'b1;
    tick(1);
    chk_st("sat_drain", 3'd3);
    tick(1);
    chk_st("sat_one_left", 3'd3);
    {mon_rvalid, mon_rready, mon_rlast} = 3'b111;
    tick(1);
    {mon_rvalid, mon_rready, mon_rlast} = 3'b000;
    chk_st("sat_last_edge", 3'd3);
    tick(1);
    chk_st("sat_req", 3'd4);

`ifdef RP_SHUTDOWN_TIMEOUT_EN
    // No ack: forced out of REQ after 100 cycles
    tick(99);
    chk_st("to_99", 3'd4);
    chk("to_99.timeout_err", {31'd0, timeout_err}, 32'd0);
    tick(1);
    chk_out("to_fire", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("to_fire.timeout_err", {31'd0, timeout_err}, 32'd1);
`else
    // No ack: REQ waits indefinitely
    tick(150);
    chk_st("no_to", 3'd4);
    chk("no_to.timeout_err", {31'd0, timeout_err}, 32'd0);
    rp_shutdown_ack = 1'b1;
    tick(1);
    rp_shutdown_ack = 1'b0;
    chk_st("no_to_ack", 3'd0);
`endif

    // timeout_err holds until the next DRAIN
    decouple_req = 1'b0;
    tick(17);
    chk_st("release5", 3'd1);
    tick(1);
    chk_st("active5", 3'd2);
`ifdef RP_SHUTDOWN_TIMEOUT_EN
    chk("active5.timeout_err", {31'd0, timeout_err}, 32'd1);
`endif
    decouple_req = 1'b1;
    tick(1);
    chk_st("drain5", 3'd3);
    chk("drain5.timeout_err", {31'd0, timeout_err}, 32'd0);
    tick(1);
    chk_st("req5", 3'd4);

    // Asynchronous reset mid-sequence
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
